// File: rtl/plic_core_mc.sv
// Multi-context PLIC core: per-source gateways with queued edges,
// claim/complete ownership and registered per-target arbitration.
module plic_core_mc #(
    parameter int SOURCES           = 8,
    parameter int TARGETS           = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 4,
    localparam int SB = $clog2(SOURCES + 1),
    localparam int PB = $clog2(PRIORITIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SOURCES-1:0]        src,
    input  logic [SOURCES-1:0]        el,
    output logic [SOURCES-1:0]        ip,
    input  logic [TARGETS*SOURCES-1:0] ie,
    input  logic [SOURCES*PB-1:0]     ipriority,
    input  logic [TARGETS*PB-1:0]     threshold,
    output logic [TARGETS-1:0]        ireq,
    output logic [TARGETS*SB-1:0]     id,
    input  logic [TARGETS-1:0]        claim,
    input  logic [TARGETS-1:0]        complete,
    input  logic [TARGETS*SB-1:0]     complete_id
);

    localparam int CB = (MAX_PENDING_COUNT > 0) ?
                        $clog2(MAX_PENDING_COUNT + 1) : 1;
    localparam int TB = (TARGETS > 1) ? $clog2(TARGETS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        INSV = 2'd2
    } gw_state_e;

    gw_state_e          state_q   [SOURCES];
    logic [CB-1:0]      cnt_q     [SOURCES];
    logic [TB-1:0]      owner_q   [SOURCES];
    logic [SOURCES-1:0] src_q;

    logic [SOURCES-1:0] edge_ev;
    logic [SOURCES-1:0] claim_hit;
    logic [SOURCES-1:0] comp_hit;
    logic [TB-1:0]      claim_tgt [SOURCES];
    logic [CB-1:0]      cnt_inc   [SOURCES];
    logic [SB-1:0]      arb_id    [TARGETS];
    logic [TARGETS-1:0] arb_req;

    // Saturating add; a zero limit pins the counter at 0 so edges are dropped.
    function automatic logic [CB-1:0] sat_inc(input logic [CB-1:0] c);
        if (int'(c) >= MAX_PENDING_COUNT)
            return CB'(MAX_PENDING_COUNT);
        return c + 1'b1;
    endfunction

    assign edge_ev = el & src & ~src_q;

    always_comb begin
        for (int s = 0; s < SOURCES; s++) begin
            ip[s]      = (state_q[s] == PEND);
            cnt_inc[s] = edge_ev[s] ? sat_inc(cnt_q[s]) : cnt_q[s];
        end
    end

    // Descending scan so the lowest claiming target is the last writer.
    always_comb begin
        claim_hit = '0;
        for (int s = 0; s < SOURCES; s++) begin
            claim_tgt[s] = '0;
            for (int t = TARGETS - 1; t >= 0; t--) begin
                if (claim[t] && id[t*SB +: SB] == SB'(s + 1)) begin
                    claim_hit[s] = 1'b1;
                    claim_tgt[s] = TB'(t);
                end
            end
        end
    end

    always_comb begin
        comp_hit = '0;
        for (int s = 0; s < SOURCES; s++) begin
            for (int t = 0; t < TARGETS; t++) begin
                if (complete[t] &&
                    complete_id[t*SB +: SB] == SB'(s + 1) &&
                    owner_q[s] == TB'(t))
                    comp_hit[s] = 1'b1;
            end
        end
    end

    always_comb begin
        logic [PB-1:0] pri;
        logic [PB-1:0] best;
        logic          found;
        pri   = '0;
        best  = '0;
        found = 1'b0;
        for (int t = 0; t < TARGETS; t++) begin
            arb_id[t]  = '0;
            arb_req[t] = 1'b0;
            best       = '0;
            found      = 1'b0;
            for (int s = 0; s < SOURCES; s++) begin
                pri = ipriority[s*PB +: PB];
                if (ip[s] && ie[t*SOURCES + s] &&
                    pri > threshold[t*PB +: PB] &&
                    pri != '0 &&
                    (!found || pri > best)) begin
                    found     = 1'b1;
                    best      = pri;
                    arb_id[t] = SB'(s + 1);
                end
            end
            arb_req[t] = found;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
            ireq  <= '0;
            id    <= '0;
            for (int s = 0; s < SOURCES; s++) begin
                state_q[s] <= IDLE;
                cnt_q[s]   <= '0;
                owner_q[s] <= '0;
            end
        end else begin
            src_q <= src;
            for (int t = 0; t < TARGETS; t++) begin
                id[t*SB +: SB] <= arb_id[t];
                ireq[t]        <= arb_req[t];
            end
            for (int s = 0; s < SOURCES; s++) begin
                case (state_q[s])
                    IDLE: begin
                        if (edge_ev[s] || (!el[s] && src[s]))
                            state_q[s] <= PEND;
                    end
                    PEND: begin
                        cnt_q[s] <= cnt_inc[s];
                        if (claim_hit[s]) begin
                            state_q[s] <= INSV;
                            owner_q[s] <= claim_tgt[s];
                        end
                    end
                    INSV: begin
                        cnt_q[s] <= cnt_inc[s];
                        if (comp_hit[s]) begin
                            if (!el[s]) begin
                                state_q[s] <= IDLE;
                            end else if (cnt_inc[s] != '0) begin
                                state_q[s] <= PEND;
                                cnt_q[s]   <= cnt_inc[s] - 1'b1;
                            end else begin
                                state_q[s] <= IDLE;
                            end
                        end
                    end
                    default: state_q[s] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plic_core_mc.sv
// Directed plus randomized bench for plic_core_mc against a
// cycle-level behavioural model of the gateway/claim/arbiter rules.
module tb_plic_core_mc;

    localparam int S  = 8;
    localparam int T  = 2;
    localparam int M  = 2;
    localparam int SB = 4;
    localparam int PB = 3;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_INSV = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [S-1:0]   src;
    logic [S-1:0]   el;
    logic [S-1:0]   ip;
    logic [T*S-1:0] ie;
    logic [S*PB-1:0] ipriority;
    logic [T*PB-1:0] threshold;
    logic [T-1:0]   ireq;
    logic [T*SB-1:0] id;
    logic [T-1:0]   claim;
    logic [T-1:0]   complete;
    logic [T*SB-1:0] complete_id;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int       mst  [S];
    int       mcnt [S];
    int       mown [S];
    int       mid  [T];
    bit       mreq [T];
    logic [S-1:0] msrcq;

    plic_core_mc #(
        .SOURCES(S),
        .TARGETS(T),
        .PRIORITIES(8),
        .MAX_PENDING_COUNT(M)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src(src),
        .el(el),
        .ip(ip),
        .ie(ie),
        .ipriority(ipriority),
        .threshold(threshold),
        .ireq(ireq),
        .id(id),
        .claim(claim),
        .complete(complete),
        .complete_id(complete_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int prio_of(input int s);
        return int'(ipriority[s*PB +: PB]);
    endfunction

    // One clock of the reference: what every source/target should hold
    // after the coming edge, given the inputs presented now.
    task automatic model_step();
        int nst [S];
        int ncnt [S];
        int nown [S];
        int nid [T];
        int best;
        int win;
        int c;
        int pr;
        bit ev;
        bit done;
        if (rst) begin
            for (int s = 0; s < S; s++) begin
                mst[s]  = M_IDLE;
                mcnt[s] = 0;
                mown[s] = 0;
            end
            for (int t = 0; t < T; t++) begin
                mid[t]  = 0;
                mreq[t] = 1'b0;
            end
            msrcq = '0;
            return;
        end
        for (int t = 0; t < T; t++) begin
            best = 0;
            for (int s = 0; s < S; s++) begin
                pr = prio_of(s);
                if (mst[s] == M_PEND && ie[t*S + s] && pr > 0 &&
                    pr > int'(threshold[t*PB +: PB]) &&
                    (best == 0 || pr > prio_of(best - 1)))
                    best = s + 1;
            end
            nid[t] = best;
        end
        for (int s = 0; s < S; s++) begin
            ev   = el[s] && src[s] && !msrcq[s];
            win  = -1;
            done = 1'b0;
            for (int t = 0; t < T; t++) begin
                if (win < 0 && claim[t] && mid[t] == s + 1)
                    win = t;
                if (complete[t] && int'(complete_id[t*SB +: SB]) == s + 1 &&
                    mst[s] == M_INSV && mown[s] == t)
                    done = 1'b1;
            end
            nst[s]  = mst[s];
            ncnt[s] = mcnt[s];
            nown[s] = mown[s];
            c = ev ? ((mcnt[s] + 1 > M) ? M : mcnt[s] + 1) : mcnt[s];
            if (mst[s] == M_IDLE) begin
                if (ev || (!el[s] && src[s]))
                    nst[s] = M_PEND;
            end else if (mst[s] == M_PEND) begin
                ncnt[s] = c;
                if (win >= 0) begin
                    nst[s]  = M_INSV;
                    nown[s] = win;
                end
            end else begin
                if (done && el[s] && c > 0) begin
                    nst[s] = M_PEND;
                    c = c - 1;
                end else if (done) begin
                    nst[s] = M_IDLE;
                end
                ncnt[s] = c;
            end
        end
        for (int s = 0; s < S; s++) begin
            mst[s]  = nst[s];
            mcnt[s] = ncnt[s];
            mown[s] = nown[s];
        end
        for (int t = 0; t < T; t++) begin
            mid[t]  = nid[t];
            mreq[t] = (nid[t] != 0);
        end
        msrcq = src;
    endtask

    task automatic tick();
        logic [S-1:0]    eip;
        logic [T-1:0]    ereq;
        logic [T*SB-1:0] eid;
        model_step();
        @(posedge clk);
        #1;
        for (int s = 0; s < S; s++)
            eip[s] = (mst[s] == M_PEND);
        for (int t = 0; t < T; t++) begin
            ereq[t]          = mreq[t];
            eid[t*SB +: SB]  = SB'(mid[t]);
        end
        chk("ip", 32'(ip), 32'(eip));
        chk("ireq", 32'(ireq), 32'(ereq));
        chk("id", 32'(id), 32'(eid));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        src      = '0;
        claim    = '0;
        complete = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_prio(input int s, input int p);
        ipriority[s*PB +: PB] = PB'(p);
    endtask

    task automatic do_claim(input logic [T-1:0] mask);
        claim = mask;
        tick();
        claim = '0;
    endtask

    task automatic do_complete(input int t, input int cid);
        complete[t]             = 1'b1;
        complete_id[t*SB +: SB] = SB'(cid);
        tick();
        complete = '0;
    endtask

    task automatic pulse(input int s);
        src[s] = 1'b1;
        tick();
        src[s] = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        src         = '0;
        el          = '0;
        ie          = '1;
        ipriority   = '0;
        threshold   = '0;
        claim       = '0;
        complete    = '0;
        complete_id = '0;
        for (int s = 0; s < S; s++) begin
            mst[s]  = M_IDLE;
            mcnt[s] = 0;
            mown[s] = 0;
        end
        for (int t = 0; t < T; t++) begin
            mid[t]  = 0;
            mreq[t] = 1'b0;
        end
        msrcq = '0;

        tick();
        tick();
        chk("rst_ip", 32'(ip), 0);
        chk("rst_ireq", 32'(ireq), 0);
        chk("rst_id", 32'(id), 0);
        rst = 1'b0;

        // level source 3, claim then complete while still high
        set_prio(2, 5);
        src[2] = 1'b1;
        tick();
        chk("t1_ip", 32'(ip[2]), 1);
        tick();
        chk("t1_id0", 32'(id[SB-1:0]), 3);
        chk("t1_ireq0", 32'(ireq[0]), 1);
        do_claim(2'b01);
        chk("t1_ip_claimed", 32'(ip[2]), 0);
        do_complete(0, 3);
        chk("t1_ip_idle", 32'(ip[2]), 0);
        tick();
        chk("t1_ip_repend", 32'(ip[2]), 1);

        // priority and lowest-ID tie-break, then threshold masking
        do_reset();
        ipriority = '0;
        set_prio(1, 4);
        set_prio(4, 4);
        set_prio(6, 6);
        src = 8'b0101_0010;
        tick();
        tick();
        chk("t2_id7", 32'(id[SB-1:0]), 7);
        do_claim(2'b01);
        tick();
        chk("t2_tie", 32'(id[SB-1:0]), 2);
        threshold[PB-1:0] = 3'd4;
        tick();
        chk("t2_thr_ireq", 32'(ireq[0]), 0);
        chk("t2_thr_id", 32'(id[SB-1:0]), 0);
        chk("t2_t1_id", 32'(id[2*SB-1:SB]), 2);
        threshold = '0;

        // edge source 1 with saturating queue of 2
        do_reset();
        ipriority = '0;
        el        = 8'b0000_0001;
        set_prio(0, 3);
        pulse(0);
        chk("t3_id", 32'(id[SB-1:0]), 1);
        do_claim(2'b01);
        for (int k = 0; k < 4; k++)
            pulse(0);
        chk("t3_insv", 32'(ip[0]), 0);
        do_complete(0, 1);
        chk("t3_repend1", 32'(ip[0]), 1);
        tick();
        do_claim(2'b01);
        do_complete(0, 1);
        chk("t3_repend2", 32'(ip[0]), 1);
        tick();
        do_claim(2'b01);
        do_complete(0, 1);
        chk("t3_idle", 32'(ip[0]), 0);
        tick();
        chk("t3_stay_idle", 32'(ip[0]), 0);

        // simultaneous claim, foreign and bogus completes
        do_reset();
        ipriority = '0;
        el        = '0;
        set_prio(3, 2);
        src[3] = 1'b1;
        tick();
        tick();
        chk("t4_id1", 32'(id[2*SB-1:SB]), 4);
        do_claim(2'b11);
        chk("t4_claimed", 32'(ip[3]), 0);
        do_complete(1, 4);
        tick();
        chk("t4_foreign", 32'(ip[3]), 0);
        do_complete(0, 0);
        do_complete(0, 9);
        tick();
        chk("t5_bogus", 32'(ip[3]), 0);
        src[3] = 1'b0;
        do_complete(0, 4);
        tick();
        chk("t4_owner_done", 32'(ip[3]), 0);

        // reset while in service; held edge source re-pends afterwards
        do_reset();
        ipriority = '0;
        el        = 8'b0010_0000;
        set_prio(5, 7);
        src[5] = 1'b1;
        tick();
        src[5] = 1'b0;
        tick();
        do_claim(2'b01);
        pulse(5);
        src[5] = 1'b1;
        rst    = 1'b1;
        tick();
        chk("t6_ip", 32'(ip), 0);
        chk("t6_ireq", 32'(ireq), 0);
        chk("t6_id", 32'(id), 0);
        rst = 1'b0;
        tick();
        chk("t6_repend", 32'(ip[5]), 1);
        src[5] = 1'b0;
        tick();
        do_claim(2'b01);
        do_complete(0, 6);
        chk("t6_cnt0", 32'(ip[5]), 0);

        // randomized traffic against the model
        do_reset();
        el = 8'($urandom);
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) begin
                ie        = 16'($urandom);
                ipriority = 24'($urandom);
                threshold = 6'($urandom_range(0, 3));
            end
            src   = 8'($urandom);
            claim = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            for (int t = 0; t < T; t++) begin
                complete[t] = ($urandom_range(0, 2) == 0);
                complete_id[t*SB +: SB] = ($urandom_range(0, 4) == 0) ?
                    SB'($urandom_range(0, 15)) : SB'($urandom_range(1, 8));
            end
            rst = ($urandom_range(0, 149) == 0);
            if (rst)
                el = 8'($urandom);
            tick();
        end
        rst      = 1'b0;
        claim    = '0;
        complete = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
